// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// ASCII command front end: parses <letter><hex digits><CR> from the UART
// receive strobe, issues one register write per good command and answers
// with a single status byte ('K' accepted, '?' rejected) over the Tx handshake.
// Optional build macro: CMD_TIMEOUT_EN -- aborts a partial command after
// TIMEOUT_CYCLES clocks without a received byte.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a command letter; CR/LF/space ignored
// S_CMD     | letter seen, collecting hex digits until CR
// S_DISCARD | malformed command, swallowing bytes until CR
// S_EXEC    | register write strobe high, 'K' loaded
// S_ERR     | error pulse high, '?' loaded
// S_SEND    | opTxSend held until UART reports busy
// S_WAIT    | waiting for UART to finish transmitting

module uart_cmd_parser #(
    parameter int DATA_W         = 32,
    parameter int MAX_DIGITS     = 8,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic              ipClk,
    input  logic              ipReset,
    input  logic [7:0]        ipRxData,
    input  logic              ipRxValid,
    output logic [7:0]        opTxData,
    output logic              opTxSend,
    input  logic              ipTxBusy,
    output logic              opRegWrite,
    output logic [1:0]        opRegAddr,
    output logic [DATA_W-1:0] opRegData,
    output logic              opError
);

    localparam int         CNT_W    = $clog2(MAX_DIGITS + 1);
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] RESP_OK  = 8'h4B;
    localparam logic [7:0] RESP_ERR = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DISCARD,
        S_EXEC,
        S_ERR,
        S_SEND,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          cmd_addr_q, cmd_addr_d;
    logic                reg_write_q, reg_write_d;
    logic [1:0]          reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]   reg_data_q, reg_data_d;
    logic                error_q, error_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_send_q, tx_send_d;

    logic                is_hex;
    logic [3:0]          hex_val;
    logic                is_letter;
    logic [1:0]          letter_addr;
    logic                timeout_hit;
    logic                do_exec;
    logic                do_err;

    // Classify the received byte as a hex digit and its nibble value.
    always_comb begin
        is_hex  = 1'b0;
        hex_val = 4'h0;
        if (ipRxData >= 8'h30 && ipRxData <= 8'h39) begin
            is_hex  = 1'b1;
            hex_val = ipRxData[3:0];
        end else if ((ipRxData >= 8'h41 && ipRxData <= 8'h46) ||
                     (ipRxData >= 8'h61 && ipRxData <= 8'h66)) begin
            is_hex  = 1'b1;
            hex_val = ipRxData[3:0] + 4'd9;
        end
    end

    // Map a case-insensitive command letter onto a register address.
    always_comb begin
        is_letter   = 1'b1;
        letter_addr = 2'd0;
        case (ipRxData)
            8'h46, 8'h66: letter_addr = 2'd0;
            8'h41, 8'h61: letter_addr = 2'd1;
            8'h50, 8'h70: letter_addr = 2'd2;
            8'h57, 8'h77: letter_addr = 2'd3;
            default:      is_letter   = 1'b0;
        endcase
    end

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Idle down-counter: reloaded by every byte, counts only mid-command.
    always_comb begin
        tmo_d = tmo_q;
        if (ipRxValid) begin
            tmo_d = TMO_W'(TIMEOUT_CYCLES - 1);
        end else if ((state_q == S_CMD || state_q == S_DISCARD) && tmo_q != '0) begin
            tmo_d = tmo_q - TMO_W'(1);
        end
    end

    assign timeout_hit = (state_q == S_CMD || state_q == S_DISCARD) &&
                         !ipRxValid && (tmo_q == '0);

    // Idle counter register.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            tmo_q <= TMO_W'(TIMEOUT_CYCLES - 1);
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;

    assign timeout_hit = 1'b0;
    // Keeps the timeout parameter referenced when the timer is compiled out.
    assign unused_tmo  = (TIMEOUT_CYCLES == 0);
`endif

    // Parser next state and next values of all registered outputs.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        cmd_addr_d  = cmd_addr_q;
        reg_write_d = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        error_d     = 1'b0;
        tx_data_d   = tx_data_q;
        tx_send_d   = tx_send_q;
        do_exec     = 1'b0;
        do_err      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ipRxValid) begin
                    if (is_letter) begin
                        state_d    = S_CMD;
                        acc_d      = '0;
                        cnt_d      = '0;
                        cmd_addr_d = letter_addr;
                    end else if (ipRxData != CH_CR && ipRxData != CH_LF &&
                                 ipRxData != CH_SP) begin
                        state_d = S_DISCARD;
                    end
                end
            end
            S_CMD: begin
                if (ipRxValid) begin
                    if (is_hex) begin
                        if (cnt_q == CNT_W'(MAX_DIGITS)) begin
                            state_d = S_DISCARD;
                        end else begin
                            acc_d = DATA_W'({acc_q, hex_val});
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (ipRxData == CH_CR) begin
                        if (cnt_q != '0) begin
                            do_exec = 1'b1;
                        end else begin
                            do_err = 1'b1;
                        end
                    end else begin
                        state_d = S_DISCARD;
                    end
                end else if (timeout_hit) begin
                    do_err = 1'b1;
                end
            end
            S_DISCARD: begin
                if (ipRxValid) begin
                    if (ipRxData == CH_CR) begin
                        do_err = 1'b1;
                    end
                end else if (timeout_hit) begin
                    do_err = 1'b1;
                end
            end
            S_EXEC, S_ERR: begin
                state_d   = S_SEND;
                tx_send_d = 1'b1;
            end
            S_SEND: begin
                if (ipTxBusy) begin
                    state_d   = S_WAIT;
                    tx_send_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (!ipTxBusy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                tx_send_d = 1'b0;
            end
        endcase

        if (do_exec) begin
            state_d     = S_EXEC;
            reg_write_d = 1'b1;
            reg_addr_d  = cmd_addr_q;
            reg_data_d  = acc_q;
            tx_data_d   = RESP_OK;
        end
        if (do_err) begin
            state_d   = S_ERR;
            error_d   = 1'b1;
            tx_data_d = RESP_ERR;
        end
    end

    // Parser state and registered outputs.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            cmd_addr_q  <= '0;
            reg_write_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            error_q     <= 1'b0;
            tx_data_q   <= '0;
            tx_send_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            cmd_addr_q  <= cmd_addr_d;
            reg_write_q <= reg_write_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            error_q     <= error_d;
            tx_data_q   <= tx_data_d;
            tx_send_q   <= tx_send_d;
        end
    end

    assign opTxData   = tx_data_q;
    assign opTxSend   = tx_send_q;
    assign opRegWrite = reg_write_q;
    assign opRegAddr  = reg_addr_q;
    assign opRegData  = reg_data_q;
    assign opError    = error_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
// Self-checking bench for uart_cmd_parser: directed and random commands
// against a string-level reference model, with a UART Tx busy emulator.
// Define CMD_TIMEOUT_EN to include the idle-timeout scenario.

module tb_uart_cmd_parser;

    typedef byte bq_t[$];

    logic        ipClk = 1'b0;
    logic        ipReset;
    logic [7:0]  ipRxData;
    logic        ipRxValid;
    logic [7:0]  opTxData;
    logic        opTxSend;
    logic        ipTxBusy;
    logic        opRegWrite;
    logic [1:0]  opRegAddr;
    logic [31:0] opRegData;
    logic        opError;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    int          wr_cnt = 0, err_cnt = 0, send_cnt = 0, send_hi = 0;
    int          stab_bad = 0, both_bad = 0;
    int          wr_cyc = 0, err_cyc = 0, send_cyc = 0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [7:0]  tx_seen = '0;
    logic        send_prev = 1'b0;

    bit busy_stuck  = 1'b0;
    bit emu_active  = 1'b0;
    int bd_lo = 0, bd_hi = 3;

    uart_cmd_parser #(
        .DATA_W(32),
        .MAX_DIGITS(8),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .ipClk(ipClk),
        .ipReset(ipReset),
        .ipRxData(ipRxData),
        .ipRxValid(ipRxValid),
        .opTxData(opTxData),
        .opTxSend(opTxSend),
        .ipTxBusy(ipTxBusy),
        .opRegWrite(opRegWrite),
        .opRegAddr(opRegAddr),
        .opRegData(opRegData),
        .opError(opError)
    );

    always #5 ipClk = ~ipClk;

    always @(posedge ipClk) cyc <= cyc + 1;

    // Observe outputs away from the active edge and record events.
    always @(negedge ipClk) begin
        if (opRegWrite) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= opRegAddr;
            wr_data <= opRegData;
            wr_cyc  <= cyc;
        end
        if (opError) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (opTxSend) send_hi <= send_hi + 1;
        if (opTxSend && !send_prev) begin
            send_cnt <= send_cnt + 1;
            tx_seen  <= opTxData;
            send_cyc <= cyc;
        end
        if (opTxSend && send_prev && opTxData !== tx_seen) stab_bad <= stab_bad + 1;
        if (opRegWrite && opError) both_bad <= both_bad + 1;
        send_prev <= opTxSend;
    end

    // UART transmitter stand-in: answers a send request with a busy burst.
    initial begin
        ipTxBusy = 1'b0;
        forever begin
            @(negedge ipClk);
            if (busy_stuck) begin
                ipTxBusy = 1'b1;
            end else if (ipTxBusy) begin
                ipTxBusy = 1'b0;
            end else if (opTxSend) begin
                emu_active = 1'b1;
                repeat ($urandom_range(bd_hi, bd_lo)) @(negedge ipClk);
                ipTxBusy = 1'b1;
                repeat ($urandom_range(5, 1)) @(negedge ipClk);
                ipTxBusy   = 1'b0;
                emu_active = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic int hexval(input byte c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    // Reference: interpret one CR-terminated line the way an operator would.
    function automatic void model(input bq_t q, output bit resp, output bit wr,
                                  output logic [1:0] addr, output logic [31:0] data);
        int i = 0;
        int n = q.size() - 1;
        int nd;
        bit ok = 1'b1;
        longint unsigned v = 0;
        resp = 1'b0; wr = 1'b0; addr = 2'd0; data = 32'd0;
        while (i < n && (q[i] == 8'h20 || q[i] == 8'h0A || q[i] == 8'h0D)) i++;
        if (i >= n) return;
        resp = 1'b1;
        case (q[i])
            "F", "f": addr = 2'd0;
            "A", "a": addr = 2'd1;
            "P", "p": addr = 2'd2;
            "W", "w": addr = 2'd3;
            default:  ok = 1'b0;
        endcase
        nd = n - i - 1;
        if (nd < 1 || nd > 8) ok = 1'b0;
        for (int k = i + 1; k < n; k++) begin
            int h = hexval(q[k]);
            if (h < 0) ok = 1'b0;
            else v = v * 16 + longint'(h);
        end
        if (ok) begin
            wr   = 1'b1;
            data = v[31:0];
        end
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic issue(input bq_t q, input int gap_max, output int last_cyc);
        last_cyc = 0;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge ipClk);
            ipRxData  = q[i];
            ipRxValid = 1'b1;
            last_cyc  = cyc;
            repeat ($urandom_range(gap_max, 0)) begin
                @(negedge ipClk);
                ipRxValid = 1'b0;
            end
        end
        @(negedge ipClk);
        ipRxValid = 1'b0;
    endtask

    task automatic settle(input bit expect_resp, input int s0, output bit timed_out);
        timed_out = 1'b0;
        if (expect_resp) begin
            timed_out = 1'b1;
            for (int k = 0; k < 300; k++) begin
                @(negedge ipClk);
                if (send_cnt != s0 && !opTxSend && !ipTxBusy && !emu_active) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end else begin
            repeat (20) @(negedge ipClk);
        end
        repeat (3) @(negedge ipClk);
    endtask

    task automatic test_reset;
        ipReset   = 1'b1;
        ipRxData  = 8'h00;
        ipRxValid = 1'b0;
        repeat (3) @(negedge ipClk);
        nvec++; if (opTxData !== 8'h00) begin nfail++; $display("FAIL reset_txdata actual=%h required=00", opTxData); end
        nvec++; if (opTxSend !== 1'b0) begin nfail++; $display("FAIL reset_txsend actual=%b required=0", opTxSend); end
        nvec++; if (opRegWrite !== 1'b0) begin nfail++; $display("FAIL reset_regwrite actual=%b required=0", opRegWrite); end
        nvec++; if (opRegAddr !== 2'd0) begin nfail++; $display("FAIL reset_regaddr actual=%0d required=0", opRegAddr); end
        nvec++; if (opRegData !== 32'd0) begin nfail++; $display("FAIL reset_regdata actual=%h required=0", opRegData); end
        nvec++; if (opError !== 1'b0) begin nfail++; $display("FAIL reset_error actual=%b required=0", opError); end
        ipReset = 1'b0;
        repeat (2) @(negedge ipClk);
    endtask

    task automatic test_directed;
        string       dcmd[5] = '{"F1A2B\r", "w3\r", "X12\r", "A\r", "F123456789\r"};
        bit          dwr[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  dad[5]  = '{2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
        logic [31:0] ddat[5] = '{32'h0000_1A2B, 32'd3, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 5; i++) begin
            int w0 = wr_cnt, e0 = err_cnt, s0 = send_cnt, last;
            bit to;
            logic [7:0] exp_tx = dwr[i] ? 8'h4B : 8'h3F;
            issue(str2q(dcmd[i]), 0, last);
            settle(1'b1, s0, to);
            nvec++; if (to) begin nfail++; $display("FAIL dir%0d_timeout actual=no_response required=response", i); end
            nvec++; if (wr_cnt - w0 != int'(dwr[i])) begin nfail++; $display("FAIL dir%0d_writes actual=%0d required=%0d", i, wr_cnt - w0, dwr[i]); end
            nvec++; if (err_cnt - e0 != int'(!dwr[i])) begin nfail++; $display("FAIL dir%0d_errors actual=%0d required=%0d", i, err_cnt - e0, !dwr[i]); end
            nvec++; if (send_cnt - s0 != 1) begin nfail++; $display("FAIL dir%0d_sends actual=%0d required=1", i, send_cnt - s0); end
            nvec++; if (tx_seen !== exp_tx) begin nfail++; $display("FAIL dir%0d_txbyte actual=%h required=%h", i, tx_seen, exp_tx); end
            if (dwr[i]) begin
                nvec++; if (wr_addr !== dad[i]) begin nfail++; $display("FAIL dir%0d_addr actual=%0d required=%0d", i, wr_addr, dad[i]); end
                nvec++; if (wr_data !== ddat[i]) begin nfail++; $display("FAIL dir%0d_data actual=%h required=%h", i, wr_data, ddat[i]); end
                nvec++; if (wr_cyc != last + 1) begin nfail++; $display("FAIL dir%0d_write_latency actual=%0d required=%0d", i, wr_cyc - last, 1); end
            end else begin
                nvec++; if (err_cyc != last + 1) begin nfail++; $display("FAIL dir%0d_error_latency actual=%0d required=%0d", i, err_cyc - last, 1); end
            end
            nvec++; if (send_cyc != last + 2) begin nfail++; $display("FAIL dir%0d_send_latency actual=%0d required=%0d", i, send_cyc - last, 2); end
        end
    endtask

    task automatic test_random;
        string lets = "FfAaPpWw";
        string bad  = "XZg!5";
        string hx   = "0123456789abcdefABCDEF";
        for (int it = 0; it < 40; it++) begin
            bq_t q;
            bit resp, wr, to;
            logic [1:0] ea;
            logic [31:0] ed;
            int w0 = wr_cnt, e0 = err_cnt, s0 = send_cnt, last, nd, r;
            repeat ($urandom_range(2, 0)) q.push_back($urandom_range(1, 0) ? 8'h20 : 8'h0A);
            r = $urandom_range(9, 0);
            if (r == 0) q.push_back(bad[$urandom_range(4, 0)]);
            else if (r != 1) q.push_back(lets[$urandom_range(7, 0)]);
            nd = $urandom_range(10, 0);
            for (int k = 0; k < nd; k++) begin
                if ($urandom_range(19, 0) == 0) q.push_back(8'h47);
                else q.push_back(hx[$urandom_range(21, 0)]);
            end
            q.push_back(8'h0D);
            model(q, resp, wr, ea, ed);
            issue(q, $urandom_range(3, 0), last);
            settle(resp, s0, to);
            nvec++; if (to) begin nfail++; $display("FAIL rnd%0d_timeout actual=no_response required=response", it); end
            nvec++; if (wr_cnt - w0 != int'(wr)) begin nfail++; $display("FAIL rnd%0d_writes actual=%0d required=%0d", it, wr_cnt - w0, wr); end
            nvec++; if (err_cnt - e0 != int'(resp && !wr)) begin nfail++; $display("FAIL rnd%0d_errors actual=%0d required=%0d", it, err_cnt - e0, resp && !wr); end
            nvec++; if (send_cnt - s0 != int'(resp)) begin nfail++; $display("FAIL rnd%0d_sends actual=%0d required=%0d", it, send_cnt - s0, resp); end
            if (resp) begin
                nvec++; if (tx_seen !== (wr ? 8'h4B : 8'h3F)) begin nfail++; $display("FAIL rnd%0d_txbyte actual=%h required=%h", it, tx_seen, wr ? 8'h4B : 8'h3F); end
            end
            if (wr) begin
                nvec++; if (wr_addr !== ea) begin nfail++; $display("FAIL rnd%0d_addr actual=%0d required=%0d", it, wr_addr, ea); end
                nvec++; if (wr_data !== ed) begin nfail++; $display("FAIL rnd%0d_data actual=%h required=%h", it, wr_data, ed); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int w0 = wr_cnt, e0 = err_cnt, s0 = send_cnt, last;
        bit to;
        bd_lo = 8; bd_hi = 8;
        issue(str2q("F5\r"), 0, last);
        issue(str2q("P5\r"), 0, last);
        settle(1'b1, s0, to);
        repeat (20) @(negedge ipClk);
        bd_lo = 0; bd_hi = 3;
        nvec++; if (to) begin nfail++; $display("FAIL b2b_timeout actual=no_response required=response"); end
        nvec++; if (wr_cnt - w0 != 1) begin nfail++; $display("FAIL b2b_writes actual=%0d required=1", wr_cnt - w0); end
        nvec++; if (wr_addr !== 2'd0 || wr_data !== 32'd5) begin nfail++; $display("FAIL b2b_write actual=%0d/%h required=0/00000005", wr_addr, wr_data); end
        nvec++; if (send_cnt - s0 != 1) begin nfail++; $display("FAIL b2b_sends actual=%0d required=1", send_cnt - s0); end
        nvec++; if (err_cnt - e0 != 0) begin nfail++; $display("FAIL b2b_errors actual=%0d required=0", err_cnt - e0); end
    endtask

    task automatic test_busy_stuck;
        int w0 = wr_cnt, s0 = send_cnt, h0 = send_hi, last;
        busy_stuck = 1'b1;
        repeat (3) @(negedge ipClk);
        issue(str2q("P7\r"), 0, last);
        repeat (10) @(negedge ipClk);
        nvec++; if (send_cnt - s0 != 1) begin nfail++; $display("FAIL stuck_sends actual=%0d required=1", send_cnt - s0); end
        nvec++; if (send_hi - h0 != 1) begin nfail++; $display("FAIL stuck_send_width actual=%0d required=1", send_hi - h0); end
        nvec++; if (wr_cnt - w0 != 1 || wr_addr !== 2'd2 || wr_data !== 32'd7) begin nfail++; $display("FAIL stuck_write actual=%0d/%0d/%h required=1/2/00000007", wr_cnt - w0, wr_addr, wr_data); end
        nvec++; if (tx_seen !== 8'h4B) begin nfail++; $display("FAIL stuck_txbyte actual=%h required=4b", tx_seen); end
        busy_stuck = 1'b0;
        repeat (5) @(negedge ipClk);
    endtask

    task automatic test_reset_mid;
        int w0 = wr_cnt, e0 = err_cnt, s0 = send_cnt, last;
        issue(str2q("F12"), 0, last);
        #2 ipReset = 1'b1;
        #1;
        nvec++; if (opTxData !== 8'h00 || opTxSend !== 1'b0 || opError !== 1'b0) begin nfail++; $display("FAIL rstmid_tx actual=%h/%b/%b required=00/0/0", opTxData, opTxSend, opError); end
        nvec++; if (opRegWrite !== 1'b0 || opRegAddr !== 2'd0 || opRegData !== 32'd0) begin nfail++; $display("FAIL rstmid_reg actual=%b/%0d/%h required=0/0/0", opRegWrite, opRegAddr, opRegData); end
        @(negedge ipClk);
        ipReset = 1'b0;
        issue(str2q("\r"), 0, last);
        repeat (20) @(negedge ipClk);
        nvec++; if (wr_cnt != w0 || err_cnt != e0 || send_cnt != s0) begin nfail++; $display("FAIL rstmid_after actual=%0d/%0d/%0d required=0/0/0", wr_cnt - w0, err_cnt - e0, send_cnt - s0); end
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout;
        int w0 = wr_cnt, e0 = err_cnt, s0 = send_cnt, last;
        bit to;
        issue(str2q("F1"), 0, last);
        settle(1'b1, s0, to);
        nvec++; if (to) begin nfail++; $display("FAIL tmo_timeout actual=no_response required=response"); end
        nvec++; if (err_cnt - e0 != 1 || wr_cnt != w0) begin nfail++; $display("FAIL tmo_events actual=err%0d/wr%0d required=err1/wr0", err_cnt - e0, wr_cnt - w0); end
        nvec++; if (err_cyc != last + 101) begin nfail++; $display("FAIL tmo_delay actual=%0d required=101", err_cyc - last); end
        nvec++; if (tx_seen !== 8'h3F) begin nfail++; $display("FAIL tmo_txbyte actual=%h required=3f", tx_seen); end
        s0 = send_cnt;
        issue(str2q("A7\r"), 0, last);
        settle(1'b1, s0, to);
        nvec++; if (wr_cnt - w0 != 1 || wr_addr !== 2'd1 || wr_data !== 32'd7) begin nfail++; $display("FAIL tmo_next actual=%0d/%0d/%h required=1/1/00000007", wr_cnt - w0, wr_addr, wr_data); end
    endtask
`endif

    task automatic test_invariants;
        nvec++; if (both_bad != 0) begin nfail++; $display("FAIL write_and_error actual=%0d required=0", both_bad); end
        nvec++; if (stab_bad != 0) begin nfail++; $display("FAIL txdata_stable actual=%0d required=0", stab_bad); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_busy_stuck;
        test_reset_mid;
`ifdef CMD_TIMEOUT_EN
        test_timeout;
`endif
        test_invariants;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
